// File: rtl/axi_isolate_ctrl.sv
// Quiesce/isolate controller for one AXI4 port on a subsystem boundary.
// Passes traffic through combinationally, caps outstanding reads and writes,
// and on request drains in-flight transactions before blocking the port.

package axi_isolate_pkg;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
  } ax_chan_t;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } w_chan_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } b_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_chan_t;

  typedef struct packed {
    ax_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    ax_chan_t ar;
    logic     ar_valid;
    logic     b_ready;
    logic     r_ready;
  } axi_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    w_ready;
    logic    ar_ready;
    b_chan_t b;
    logic    b_valid;
    r_chan_t r;
    logic    r_valid;
  } axi_rsp_t;

endpackage

// state   | meaning
// NORMAL  | full pass-through, AW/AR held off only at the outstanding limit
// DRAIN   | no new AW/AR; in-flight W, B and R finish
// ISOLATE | port fully blocked in both directions, isolated_o = 1
module axi_isolate_ctrl #(
  parameter int unsigned MaxTxns   = 8,
  parameter type         axi_req_t = axi_isolate_pkg::axi_req_t,
  parameter type         axi_rsp_t = axi_isolate_pkg::axi_rsp_t
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     isolate_i,
  output logic     isolated_o,
  input  axi_req_t slv_req_i,
  output axi_rsp_t slv_resp_o,
  output axi_req_t mst_req_o,
  input  axi_rsp_t mst_resp_i
);

  localparam int unsigned     CntW   = $clog2(MaxTxns + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MaxTxns);

  typedef enum logic [1:0] {
    NORMAL  = 2'd0,
    DRAIN   = 2'd1,
    ISOLATE = 2'd2
  } state_e;

  state_e          state_q;
  logic            isolated_q;
  logic [CntW-1:0] wr_cnt_q, wr_cnt_d;
  logic [CntW-1:0] rd_cnt_q, rd_cnt_d;
  logic            aw_pend_q, aw_pend_d;
  logic            ar_pend_q, ar_pend_d;
  logic            w_open_q, w_open_d;

  logic gate_aw, gate_ar, gate_all;
  logic aw_hs, ar_hs, w_hs, b_hs, r_last_hs;
  logic drained;

  // Decide which channels are blocked in the current state.
  always_comb begin
    gate_all = (state_q == ISOLATE);
    gate_aw  = 1'b1;
    gate_ar  = 1'b1;
    case (state_q)
      NORMAL: begin
        // A pending address is already committed on the bus, so it is never cut off.
        gate_aw = (wr_cnt_q == CntMax) && !aw_pend_q;
        gate_ar = (rd_cnt_q == CntMax) && !ar_pend_q;
      end
      DRAIN: begin
        gate_aw = !aw_pend_q;
        gate_ar = !ar_pend_q;
      end
      default: begin
        gate_aw = 1'b1;
        gate_ar = 1'b1;
      end
    endcase
  end

  // Pass payloads straight through; gating kills valid and ready as a pair.
  always_comb begin
    mst_req_o          = slv_req_i;
    mst_req_o.aw_valid = slv_req_i.aw_valid & ~gate_aw;
    mst_req_o.w_valid  = slv_req_i.w_valid  & ~gate_all;
    mst_req_o.ar_valid = slv_req_i.ar_valid & ~gate_ar;
    mst_req_o.b_ready  = slv_req_i.b_ready  & ~gate_all;
    mst_req_o.r_ready  = slv_req_i.r_ready  & ~gate_all;

    slv_resp_o          = mst_resp_i;
    slv_resp_o.aw_ready = mst_resp_i.aw_ready & ~gate_aw;
    slv_resp_o.w_ready  = mst_resp_i.w_ready  & ~gate_all;
    slv_resp_o.ar_ready = mst_resp_i.ar_ready & ~gate_ar;
    slv_resp_o.b_valid  = mst_resp_i.b_valid  & ~gate_all;
    slv_resp_o.r_valid  = mst_resp_i.r_valid  & ~gate_all;
  end

  assign aw_hs     = mst_req_o.aw_valid & mst_resp_i.aw_ready;
  assign ar_hs     = mst_req_o.ar_valid & mst_resp_i.ar_ready;
  assign w_hs      = mst_req_o.w_valid  & mst_resp_i.w_ready;
  assign b_hs      = slv_resp_o.b_valid & slv_req_i.b_ready;
  assign r_last_hs = slv_resp_o.r_valid & slv_req_i.r_ready & slv_resp_o.r.last;

  assign drained = (wr_cnt_q == '0) && (rd_cnt_q == '0)
                   && !aw_pend_q && !ar_pend_q && !w_open_q;

  // Next values of the outstanding counters and in-flight flags.
  always_comb begin
    wr_cnt_d = wr_cnt_q;
    if (aw_hs && !b_hs) begin
      if (wr_cnt_q != CntMax) wr_cnt_d = wr_cnt_q + 1'b1;
    end else if (b_hs && !aw_hs) begin
      if (wr_cnt_q != '0) wr_cnt_d = wr_cnt_q - 1'b1;
    end

    rd_cnt_d = rd_cnt_q;
    if (ar_hs && !r_last_hs) begin
      if (rd_cnt_q != CntMax) rd_cnt_d = rd_cnt_q + 1'b1;
    end else if (r_last_hs && !ar_hs) begin
      if (rd_cnt_q != '0) rd_cnt_d = rd_cnt_q - 1'b1;
    end

    aw_pend_d = mst_req_o.aw_valid & ~mst_resp_i.aw_ready;
    ar_pend_d = mst_req_o.ar_valid & ~mst_resp_i.ar_ready;

    w_open_d = w_open_q;
    if (w_hs) w_open_d = ~mst_req_o.w.last;
  end

  // Register the counters and flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      aw_pend_q <= 1'b0;
      ar_pend_q <= 1'b0;
      w_open_q  <= 1'b0;
    end else begin
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      aw_pend_q <= aw_pend_d;
      ar_pend_q <= ar_pend_d;
      w_open_q  <= w_open_d;
    end
  end

  // Sequence NORMAL -> DRAIN -> ISOLATE on the registered drain status.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= NORMAL;
      isolated_q <= 1'b0;
    end else begin
      case (state_q)
        NORMAL: begin
          if (isolate_i) state_q <= DRAIN;
        end
        DRAIN: begin
          if (!isolate_i) begin
            state_q <= NORMAL;
          end else if (drained) begin
            state_q    <= ISOLATE;
            isolated_q <= 1'b1;
          end
        end
        ISOLATE: begin
          if (!isolate_i) begin
            state_q    <= NORMAL;
            isolated_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= NORMAL;
          isolated_q <= 1'b0;
        end
      endcase
    end
  end

  assign isolated_o = isolated_q;

  // A response with nothing outstanding is a protocol fault on one side or the other.
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!(b_hs && !aw_hs && (wr_cnt_q == '0)))
        else $error("axi_isolate_ctrl: B response without outstanding write");
      assert (!(r_last_hs && !ar_hs && (rd_cnt_q == '0)))
        else $error("axi_isolate_ctrl: R last without outstanding read");
    end
  end

endmodule
